// File: rtl/vector_pkg.sv
// Shared constants for the SIMD lane ALU: operation encodings and default geometry.
package vector_pkg;

  localparam int unsigned SIZE_DEFAULT = 3072;
  localparam int unsigned LANE_DEFAULT = 32;

  localparam logic [1:0] MOD_ADD = 2'd0;
  localparam logic [1:0] MOD_SUB = 2'd1;
  localparam logic [1:0] MOD_AND = 2'd2;
  localparam logic [1:0] MOD_XOR = 2'd3;

endpackage

// File: rtl/vector_lane.sv
// Combinational single-lane operation; each instance is isolated, so carries never leave the lane.
module vector_lane
  import vector_pkg::*;
#(
  parameter int unsigned LANE = LANE_DEFAULT
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic [1:0]      mod,
  output logic [LANE-1:0] y
);

  always_comb begin
    y = '0;
    unique case (mod)
      MOD_ADD: y = a + b;
      MOD_SUB: y = a - b;
      MOD_AND: y = a & b;
      MOD_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_unit.sv
// Wide SIMD execute stage: NLANES independent lane ALUs feeding one registered result.
module vector_unit
  import vector_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT,
  parameter int unsigned LANE = LANE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic [1:0]      mod,
  output logic [SIZE-1:0] out
);

  localparam int unsigned NLANES = SIZE / LANE;

  if (SIZE % LANE != 0) begin : g_size_check
    $error("vector_unit: SIZE (%0d) must be a multiple of LANE (%0d)", SIZE, LANE);
  end

  logic [SIZE-1:0] out_d;
  logic [SIZE-1:0] out_q;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    vector_lane #(
      .LANE(LANE)
    ) u_lane (
      .a  (A[i*LANE +: LANE]),
      .b  (B[i*LANE +: LANE]),
      .mod(mod),
      .y  (out_d[i*LANE +: LANE])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_vector_unit.sv
// Self-checking bench for vector_unit: directed cases plus randomized traffic against a lane model.
module tb_vector_unit;

  localparam int unsigned SIZE   = 3072;
  localparam int unsigned LANE   = 32;
  localparam int unsigned NLANES = SIZE / LANE;

  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic [1:0]      mod;
  logic [SIZE-1:0] out;

  int checks;
  int errors;

  vector_unit #(
    .SIZE(SIZE),
    .LANE(LANE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .mod  (mod),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reports the first differing lane only, keeping lines short for 3072-bit values.
  task automatic check(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
    int l;
    checks++;
    if (got !== exp) begin
      errors++;
      l = 0;
      for (int i = 0; i < NLANES; i++) begin
        if (got[i*LANE +: LANE] !== exp[i*LANE +: LANE]) begin
          l = i;
          break;
        end
      end
      $display("FAIL %s: lane %0d got %h expected %h", tag, l,
               got[l*LANE +: LANE], exp[l*LANE +: LANE]);
    end
  endtask

  // Lane-wise reference computed with 64-bit arithmetic and explicit modulo.
  function automatic logic [SIZE-1:0] model(input logic [SIZE-1:0] a_v, input logic [SIZE-1:0] b_v,
                                            input logic [1:0] op);
    logic [SIZE-1:0] r;
    longint unsigned m, a, b, y;
    m = 64'd1 << LANE;
    r = '0;
    for (int i = 0; i < NLANES; i++) begin
      a = 64'(a_v[i*LANE +: LANE]);
      b = 64'(b_v[i*LANE +: LANE]);
      case (op)
        2'd0:    y = (a + b) % m;
        2'd1:    y = (a + m - b) % m;
        2'd2:    y = a & b;
        default: y = a ^ b;
      endcase
      r[i*LANE +: LANE] = y[LANE-1:0];
    end
    return r;
  endfunction

  function automatic logic [LANE-1:0] rand_lane();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return LANE'(1);
      3:       return {1'b1, {(LANE-1){1'b0}}};
      default: return LANE'($urandom());
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [SIZE-1:0] exp_v;
  logic [SIZE-1:0] seq_exp [4];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    mod    = 2'd0;
    A      = '1;
    B      = '1;

    // Reset holds out at zero even with nonzero operands.
    step();
    check("reset_edge1", out, '0);
    step();
    check("reset_edge2", out, '0);

    A     = SIZE'(32'h0000ffff);
    B     = SIZE'(32'h0abcffff);
    mod   = 2'd0;
    rst_n = 1'b1;
    step();
    check("add_basic", out, SIZE'(32'h0abdfffe));
    mod = 2'd1;
    step();
    check("sub_basic", out, SIZE'(32'hf5440000));
    mod = 2'd2;
    step();
    check("and_basic", out, SIZE'(32'h0000ffff));
    mod = 2'd3;
    step();
    check("xor_basic", out, SIZE'(32'h0abc0000));

    // Carry out of lane 0 must not reach lane 1.
    A   = SIZE'(32'hffffffff);
    B   = SIZE'(32'h00000001);
    mod = 2'd0;
    step();
    check("add_no_carry", out, '0);
    A   = '0;
    mod = 2'd1;
    step();
    check("sub_no_borrow", out, SIZE'(32'hffffffff));

    // Carry isolation at a mid-vector boundary too.
    A = '0;
    B = '0;
    A[40*LANE +: LANE] = '1;
    B[40*LANE +: LANE] = LANE'(2);
    mod = 2'd0;
    step();
    exp_v = '0;
    exp_v[40*LANE +: LANE] = LANE'(1);
    check("add_mid_lane", out, exp_v);

    // Back-to-back mod changes, each result one edge after its mod.
    A = SIZE'(32'h0000ffff);
    B = SIZE'(32'h0abcffff);
    seq_exp[0] = SIZE'(32'h0abdfffe);
    seq_exp[1] = SIZE'(32'hf5440000);
    seq_exp[2] = SIZE'(32'h0000ffff);
    seq_exp[3] = SIZE'(32'h0abc0000);
    for (int k = 0; k < 4; k++) begin
      mod = 2'(k);
      step();
      check($sformatf("b2b_mod%0d", k), out, seq_exp[k]);
    end

    // Synchronous reset overrides an operation mid-stream.
    A     = '1;
    B     = '1;
    mod   = 2'd0;
    rst_n = 1'b0;
    step();
    check("reset_override", out, '0);
    rst_n = 1'b1;

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NLANES; i++) begin
        A[i*LANE +: LANE] = rand_lane();
        B[i*LANE +: LANE] = rand_lane();
      end
      mod   = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 49) != 0);
      exp_v = rst_n ? model(A, B, mod) : '0;
      step();
      check("random", out, exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
